// File: rtl/palette_engine.sv
`default_nettype none
// ============================================================================
// Module   : palette_engine
// Purpose  : Runtime-programmable colour palette. Maps a per-pixel colour
//            index to {R,G,B} across BANKS switchable palettes, scales the
//            result by a frame-synchronous fade level and delivers it
//            through a 2-stage registered pipeline (latency 2).
// Ports    : Clk, Reset       - clock, asynchronous active-high reset
//            pix_valid, index, bank_sel   - pixel lookup request
//            wr_en, wr_bank, wr_addr, wr_data - palette entry write
//            frame_start, fade_req, fade_dir  - fade control
//            red, green, blue, out_valid      - scaled pixel colour
//            fade_busy, fade_level            - fade status (0..2**CH_W)
//            transparent (PALETTE_TRANSPARENT_EN only) - index-0 colour key
// Options  : define PALETTE_TRANSPARENT_EN to add the `transparent` output.
// Revision : 1.0 - initial release
// ============================================================================
module palette_engine #(
  parameter  int unsigned INDEX_W   = 4,
  parameter  int unsigned CH_W      = 4,
  parameter  int unsigned BANKS     = 2,
  parameter  int unsigned FADE_STEP = 1,
  localparam int unsigned BSEL_W    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                pix_valid,
  input  logic [INDEX_W-1:0]  index,
  input  logic [BSEL_W-1:0]   bank_sel,
  input  logic                wr_en,
  input  logic [BSEL_W-1:0]   wr_bank,
  input  logic [INDEX_W-1:0]  wr_addr,
  input  logic [3*CH_W-1:0]   wr_data,
  input  logic                frame_start,
  input  logic                fade_req,
  input  logic                fade_dir,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue,
  output logic                out_valid,
  output logic                fade_busy,
  output logic [CH_W:0]       fade_level
`ifdef PALETTE_TRANSPARENT_EN
  ,
  output logic                transparent
`endif
);

  localparam int unsigned ENTRIES  = 2 ** INDEX_W;
  localparam int unsigned SLOTS    = 2 ** BSEL_W;
  localparam int unsigned COL_W    = 3 * CH_W;
  localparam int unsigned LVL_W    = CH_W + 1;
  localparam int unsigned MUL_W    = 2 * CH_W + 1;
  localparam int unsigned LVL_FULL = 2 ** CH_W;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LVL_FULL);

  // --------------------------------------------------------------------------
  // Palette storage. The array is padded to a power-of-two number of bank
  // slots; slots at or above BANKS read as black and have no storage, so an
  // out-of-range bank_sel yields 0 and an out-of-range wr_bank matches no
  // entry and is silently dropped.
  // --------------------------------------------------------------------------
  logic [COL_W-1:0] palette [SLOTS][ENTRIES];

  for (genvar b = 0; b < SLOTS; b++) begin : g_bank
    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
      if (b < BANKS) begin : g_live
        // Reset value is a grey ramp spanning the full channel range.
        localparam logic [CH_W-1:0] GREY =
          CH_W'((e * (2 ** CH_W - 1)) / (2 ** INDEX_W - 1));

        logic [COL_W-1:0] entry;

        always_ff @(posedge Clk or posedge Reset) begin
          if (Reset) begin
            entry <= {GREY, GREY, GREY};
          end else if (wr_en && (wr_bank == BSEL_W'(b)) && (wr_addr == INDEX_W'(e))) begin
            entry <= wr_data;
          end
        end

        assign palette[b][e] = entry;
      end else begin : g_void
        assign palette[b][e] = '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: palette lookup. Entries are registers updated with <=, so a
  // same-cycle write to the entry being read is seen here as the old value.
  // --------------------------------------------------------------------------
  logic             s1_valid;
  logic [COL_W-1:0] s1_color;
`ifdef PALETTE_TRANSPARENT_EN
  logic             s1_key;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_color <= '0;
`ifdef PALETTE_TRANSPARENT_EN
      s1_key   <= 1'b0;
`endif
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1_color <= palette[bank_sel][index];
`ifdef PALETTE_TRANSPARENT_EN
        s1_key   <= (index == '0);
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: brightness scaling, (ch * level) >> CH_W. Level 2**CH_W is
  // unity gain, so full brightness reproduces the palette value exactly.
  // --------------------------------------------------------------------------
  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0]  ch,
                                            input logic [LVL_W-1:0] lvl);
    logic [MUL_W-1:0] prod;
    prod = MUL_W'(ch) * MUL_W'(lvl);
    return CH_W'(prod >> CH_W);
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid   <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
`ifdef PALETTE_TRANSPARENT_EN
      transparent <= 1'b0;
`endif
    end else begin
      out_valid <= s1_valid;
      // Colour outputs hold their last value between valid pixels.
      if (s1_valid) begin
        red         <= scale(s1_color[3*CH_W-1:2*CH_W], fade_level);
        green       <= scale(s1_color[2*CH_W-1:CH_W],   fade_level);
        blue        <= scale(s1_color[CH_W-1:0],        fade_level);
`ifdef PALETTE_TRANSPARENT_EN
        transparent <= s1_key;
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // Fade engine. A request is only accepted in IDLE; the level then moves
  // by FADE_STEP on every frame_start until it clamps at 0 or full.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } fade_state_t;

  fade_state_t      state;
  fade_state_t      state_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic [31:0]      lvl_wide;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      fade_level <= LVL_MAX;
    end else begin
      state      <= state_nxt;
      fade_level <= level_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    level_nxt = fade_level;
    lvl_wide  = 32'(fade_level);
    case (state)
      IDLE: begin
        // A frame_start coinciding with the request does not step.
        if (fade_req) begin
          state_nxt = fade_dir ? FADE_IN : FADE_OUT;
        end
      end
      FADE_OUT: begin
        if (frame_start) begin
          if (lvl_wide <= FADE_STEP) begin
            level_nxt = '0;
            state_nxt = IDLE;
          end else begin
            level_nxt = LVL_W'(lvl_wide - FADE_STEP);
          end
        end
      end
      FADE_IN: begin
        if (frame_start) begin
          if (lvl_wide + FADE_STEP >= LVL_FULL) begin
            level_nxt = LVL_MAX;
            state_nxt = IDLE;
          end else begin
            level_nxt = LVL_W'(lvl_wide + FADE_STEP);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign fade_busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_palette_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_palette_engine
// Purpose  : Self-checking bench for palette_engine (BANKS=3, FADE_STEP=4)
//            with directed scenarios and randomized traffic compared
//            against a behavioural model of palette, fade and latency.
// Options  : honours PALETTE_TRANSPARENT_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_palette_engine;

  localparam int INDEX_W   = 4;
  localparam int CH_W      = 4;
  localparam int BANKS     = 3;
  localparam int FADE_STEP = 4;
  localparam int BSEL_W    = 2;
  localparam int FULL      = 2 ** CH_W;
  localparam int NENT      = 2 ** INDEX_W;

  logic clk = 1'b0;
  logic rst;
  logic pix_valid;
  logic [INDEX_W-1:0] index;
  logic [BSEL_W-1:0] bank_sel;
  logic wr_en;
  logic [BSEL_W-1:0] wr_bank;
  logic [INDEX_W-1:0] wr_addr;
  logic [3*CH_W-1:0] wr_data;
  logic frame_start, fade_req, fade_dir;
  logic [CH_W-1:0] red, green, blue;
  logic out_valid, fade_busy;
  logic [CH_W:0] fade_level;
`ifdef PALETTE_TRANSPARENT_EN
  logic transparent;
`endif

  always #5 clk = ~clk;

  palette_engine #(
    .INDEX_W(INDEX_W), .CH_W(CH_W), .BANKS(BANKS), .FADE_STEP(FADE_STEP)
  ) dut (
    .Clk(clk), .Reset(rst), .pix_valid(pix_valid), .index(index),
    .bank_sel(bank_sel), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_start(frame_start), .fade_req(fade_req),
    .fade_dir(fade_dir), .red(red), .green(green), .blue(blue),
    .out_valid(out_valid), .fade_busy(fade_busy), .fade_level(fade_level)
`ifdef PALETTE_TRANSPARENT_EN
    , .transparent(transparent)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: palette contents, brightness, fade mode
  // (0 idle, 1 fading out, 2 fading in), pending pixel and expected outputs.
  int pal [BANKS][NENT];
  int level, mode;
  int p_valid, p_r, p_g, p_b, p_idx;
  int exp_r, exp_g, exp_b, exp_ov, exp_tr;

  task automatic model_reset();
    for (int b = 0; b < BANKS; b++)
      for (int e = 0; e < NENT; e++) begin
        int g;
        g = e * (FULL - 1) / (NENT - 1);
        pal[b][e] = (g << (2*CH_W)) | (g << CH_W) | g;
      end
    level = FULL; mode = 0;
    p_valid = 0; p_r = 0; p_g = 0; p_b = 0; p_idx = 1;
    exp_r = 0; exp_g = 0; exp_b = 0; exp_ov = 0; exp_tr = 0;
  endtask

  task automatic idle_inputs();
    pix_valid = 0; index = '0; bank_sel = '0;
    wr_en = 0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    frame_start = 0; fade_req = 0; fade_dir = 0;
  endtask

  // Advance one clock edge on both DUT and model, then settle 1 time unit.
  task automatic tick();
    @(posedge clk);
    if (p_valid != 0) begin
      exp_r  = (p_r * level) >> CH_W;
      exp_g  = (p_g * level) >> CH_W;
      exp_b  = (p_b * level) >> CH_W;
      exp_tr = (p_idx == 0) ? 1 : 0;
    end
    exp_ov = p_valid;
    if (mode == 0) begin
      if (fade_req) mode = fade_dir ? 2 : 1;
    end else if (mode == 1 && frame_start) begin
      level = level - FADE_STEP;
      if (level <= 0) begin level = 0; mode = 0; end
    end else if (mode == 2 && frame_start) begin
      level = level + FADE_STEP;
      if (level >= FULL) begin level = FULL; mode = 0; end
    end
    p_valid = pix_valid ? 1 : 0;
    p_idx   = int'(index);
    if (int'(bank_sel) < BANKS) begin
      p_r = (pal[bank_sel][index] >> (2*CH_W)) & (FULL - 1);
      p_g = (pal[bank_sel][index] >> CH_W) & (FULL - 1);
      p_b = pal[bank_sel][index] & (FULL - 1);
    end else begin
      p_r = 0; p_g = 0; p_b = 0;
    end
    if (wr_en && int'(wr_bank) < BANKS) pal[wr_bank][wr_addr] = int'(wr_data);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    model_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0d want 0", out_valid); end
    checks++; if (fade_busy !== 1'b0) begin errors++; $display("FAIL reset_fade_busy got %0d want 0", fade_busy); end
    checks++; if (fade_level !== 5'd16) begin errors++; $display("FAIL reset_fade_level got %0d want 16", fade_level); end
    checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", {red, green, blue}); end
`ifdef PALETTE_TRANSPARENT_EN
    checks++; if (transparent !== 1'b0) begin errors++; $display("FAIL reset_transparent got %0d want 0", transparent); end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    idle_inputs();
    pix_valid = 1; index = 4'd9; bank_sel = 2'd0;
    tick();
    idle_inputs();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency1 out_valid got %0d want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency2 out_valid got %0d want 1", out_valid); end
    checks++; if ({red, green, blue} !== 12'h999) begin errors++; $display("FAIL basic_rgb got %h want 999", {red, green, blue}); end
    checks++; if (fade_level !== 5'd16) begin errors++; $display("FAIL basic_level got %0d want 16", fade_level); end
    tick();
    checks++; if (out_valid !== 1'b0 || {red, green, blue} !== 12'h999) begin
      errors++; $display("FAIL basic_hold got v=%0d rgb=%h want v=0 rgb=999", out_valid, {red, green, blue}); end
  endtask

  task automatic test_write();
    idle_inputs();
    wr_en = 1; wr_bank = 2'd1; wr_addr = 4'd3; wr_data = 12'hF80;
    tick();
    idle_inputs();
    pix_valid = 1; bank_sel = 2'd1; index = 4'd3;
    tick();
    pix_valid = 1; bank_sel = 2'd0; index = 4'd5;
    wr_en = 1; wr_bank = 2'd0; wr_addr = 4'd5; wr_data = 12'h123;
    tick();
    checks++; if ({red, green, blue} !== 12'hF80) begin errors++; $display("FAIL write_new_entry got %h want f80", {red, green, blue}); end
    wr_en = 0;
    tick();
    checks++; if ({red, green, blue} !== 12'h555) begin errors++; $display("FAIL write_read_first got %h want 555", {red, green, blue}); end
    idle_inputs();
    tick();
    checks++; if ({red, green, blue} !== 12'h123) begin errors++; $display("FAIL write_after got %h want 123", {red, green, blue}); end
  endtask

  task automatic test_bounds();
    logic [BSEL_W-1:0]  banks [5];
    logic [INDEX_W-1:0] idxs  [5];
    logic [CH_W-1:0]    want  [5];
    banks = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd2};
    idxs  = '{4'd9, 4'd7, 4'd7, 4'd7, 4'd15};
    want  = '{4'd0, 4'd7, 4'd7, 4'd7, 4'd15};
    idle_inputs();
    wr_en = 1; wr_bank = 2'd3; wr_addr = 4'd7; wr_data = 12'hABC;
    tick();
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      if (i < 5) begin pix_valid = 1; bank_sel = banks[i]; index = idxs[i]; end
      tick();
      if (i >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || {red, green, blue} !== {want[i-1], want[i-1], want[i-1]}) begin
          errors++;
          $display("FAIL bounds_item%0d got v=%0d rgb=%h want v=1 rgb=%h", i-1, out_valid,
                   {red, green, blue}, {want[i-1], want[i-1], want[i-1]});
        end
      end
    end
  endtask

  task automatic test_transparent();
`ifdef PALETTE_TRANSPARENT_EN
    idle_inputs();
    pix_valid = 1; bank_sel = 2'd1; index = 4'd0;
    tick();
    index = 4'd1;
    tick();
    idle_inputs();
    checks++; if (transparent !== 1'b1) begin errors++; $display("FAIL transparent_idx0 got %0d want 1", transparent); end
    tick();
    checks++; if (transparent !== 1'b0) begin errors++; $display("FAIL transparent_idx1 got %0d want 0", transparent); end
`endif
  endtask

  task automatic test_fade_out();
    idle_inputs();
    fade_req = 1; fade_dir = 0;
    tick();
    idle_inputs();
    checks++; if (fade_busy !== 1'b1 || fade_level !== 5'd16) begin
      errors++; $display("FAIL fade_out_start got busy=%0d lvl=%0d want busy=1 lvl=16", fade_busy, fade_level); end
    fade_req = 1; fade_dir = 1;
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      frame_start = 1;
      tick();
      idle_inputs();
      checks++; if (fade_level !== 5'(FULL - FADE_STEP * (k + 1))) begin
        errors++; $display("FAIL fade_out_level%0d got %0d want %0d", k, fade_level, FULL - FADE_STEP * (k + 1)); end
      checks++; if (fade_busy !== (k < 3)) begin
        errors++; $display("FAIL fade_out_busy%0d got %0d want %0d", k, fade_busy, k < 3); end
      if (k == 1 || k == 3) begin
        pix_valid = 1;
        bank_sel  = (k == 1) ? 2'd1 : 2'd0;
        index     = (k == 1) ? 4'd3 : 4'd9;
        tick();
        idle_inputs();
        tick();
        checks++; if ({red, green, blue} !== ((k == 1) ? 12'h740 : 12'h000)) begin
          errors++; $display("FAIL fade_out_pixel%0d got %h want %h", k, {red, green, blue},
                             (k == 1) ? 12'h740 : 12'h000); end
      end
    end
  endtask

  task automatic test_fade_in();
    int pulses;
    idle_inputs();
    fade_req = 1; fade_dir = 1; frame_start = 1;
    tick();
    idle_inputs();
    checks++; if (fade_busy !== 1'b1 || fade_level !== 5'd0) begin
      errors++; $display("FAIL fade_in_accept got busy=%0d lvl=%0d want busy=1 lvl=0", fade_busy, fade_level); end
    pulses = 0;
    while (fade_busy === 1'b1 && pulses < 20) begin
      frame_start = 1;
      tick();
      idle_inputs();
      tick();
      pulses++;
      checks++; if (fade_level !== 5'(level)) begin
        errors++; $display("FAIL fade_in_step%0d got %0d want %0d", pulses, fade_level, level); end
    end
    checks++; if (pulses != FULL / FADE_STEP || fade_level !== 5'd16) begin
      errors++; $display("FAIL fade_in_frames got %0d frames lvl=%0d want %0d frames lvl=16",
                         pulses, fade_level, FULL / FADE_STEP); end
    fade_req = 1; fade_dir = 1;
    tick();
    idle_inputs();
    checks++; if (fade_busy !== 1'b1) begin errors++; $display("FAIL fade_in_at_full_busy got %0d want 1", fade_busy); end
    frame_start = 1;
    tick();
    idle_inputs();
    checks++; if (fade_busy !== 1'b0 || fade_level !== 5'd16) begin
      errors++; $display("FAIL fade_in_at_full_done got busy=%0d lvl=%0d want busy=0 lvl=16", fade_busy, fade_level); end
  endtask

  task automatic test_reset_mid_fade();
    idle_inputs();
    fade_req = 1; fade_dir = 0;
    tick();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin frame_start = 1; tick(); end
    idle_inputs();
    pix_valid = 1; index = 4'd9;
    tick();
    tick();
    checks++; if (fade_level !== 5'd8 || out_valid !== 1'b1) begin
      errors++; $display("FAIL midfade_pre got lvl=%0d v=%0d want lvl=8 v=1", fade_level, out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (fade_level !== 5'd16 || fade_busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midfade_reset got lvl=%0d busy=%0d v=%0d want lvl=16 busy=0 v=0",
                         fade_level, fade_busy, out_valid); end
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      pix_valid   = ($urandom % 4) != 0;
      index       = INDEX_W'($urandom);
      bank_sel    = BSEL_W'($urandom);
      wr_en       = ($urandom % 4) == 0;
      wr_bank     = BSEL_W'($urandom);
      wr_addr     = INDEX_W'($urandom);
      wr_data     = 12'($urandom);
      frame_start = ($urandom % 6) == 0;
      fade_req    = ($urandom % 16) == 0;
      fade_dir    = 1'($urandom);
      tick();
      checks++; if (out_valid !== 1'(exp_ov)) begin
        errors++; $display("FAIL rand_valid cyc%0d got %0d want %0d", n, out_valid, exp_ov); end
      checks++; if ({red, green, blue} !== {4'(exp_r), 4'(exp_g), 4'(exp_b)}) begin
        errors++; $display("FAIL rand_rgb cyc%0d got %h want %h", n, {red, green, blue},
                           {4'(exp_r), 4'(exp_g), 4'(exp_b)}); end
      checks++; if (fade_level !== 5'(level) || fade_busy !== (mode != 0)) begin
        errors++; $display("FAIL rand_fade cyc%0d got lvl=%0d busy=%0d want lvl=%0d busy=%0d",
                           n, fade_level, fade_busy, level, mode != 0); end
`ifdef PALETTE_TRANSPARENT_EN
      checks++; if (transparent !== 1'(exp_tr)) begin
        errors++; $display("FAIL rand_transparent cyc%0d got %0d want %0d", n, transparent, exp_tr); end
`endif
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    test_reset();
    test_basic();
    test_write();
    test_bounds();
    test_transparent();
    test_fade_out();
    test_fade_in();
    test_reset_mid_fade();
    test_random();
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/palette_engine.md
Name: palette_engine

Overview:
- Runtime-programmable colour palette for the sprite/background renderers.
- Maps a per-pixel colour index to 12-bit (default) RGB across BANKS switchable palettes.
- Includes a frame-synchronous fade engine for level transitions and a 2-stage registered pipeline.
- Sits between the sprite ROM index outputs and the VGA colour mux.

Parameters:
- INDEX_W, 4, colour index width; entries per bank = 2**INDEX_W
- CH_W, 4, bits per colour channel
- BANKS, 2, number of palettes (1..8, need not be a power of two)
- FADE_STEP, 1, level change per frame while fading

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- pix_valid  in  1  index/bank_sel valid this cycle
- index  in  INDEX_W  colour index
- bank_sel  in  max(1,$clog2(BANKS))  palette bank for this pixel
- wr_en  in  1  palette write strobe
- wr_bank  in  max(1,$clog2(BANKS))  bank to write
- wr_addr  in  INDEX_W  entry to write
- wr_data  in  3*CH_W  {R,G,B} entry value
- frame_start  in  1  one-cycle pulse per frame (vsync edge)
- fade_req  in  1  one-cycle fade request
- fade_dir  in  1  0 = fade out to black, 1 = fade in to full
- red, green, blue  out  CH_W  pixel colour
- out_valid  out  1  red/green/blue valid
- fade_busy  out  1  fade in progress
- fade_level  out  CH_W+1  current brightness, 0..2**CH_W

Behaviour:
- Reset (async, active-high):
  - Every entry e of every bank = grey ramp {g,g,g}, g = (e*(2**CH_W-1))/(2**INDEX_W-1), truncated. For 4/4 this is g = e.
  - fade_level = 2**CH_W (full). FSM = IDLE.
  - red/green/blue = 0, out_valid = 0, fade_busy = 0.
- Pipeline, latency 2 cycles:
  - S1: register palette[bank_sel][index] and pix_valid.
  - S2: each channel out = (ch * fade_level) >> CH_W, computed at width 2*CH_W+1, then truncated to CH_W.
  - out_valid = pix_valid delayed 2 cycles.
  - Outputs hold their last value when out_valid = 0.
- fade_level is sampled in S2. A level change mid-frame therefore applies from the next S2 cycle.
- Writes:
  - Take effect at the clock edge where wr_en = 1.
  - Read/write to the same entry in the same cycle: S1 captures the OLD value (read-first).
  - wr_bank >= BANKS: write ignored.
  - bank_sel >= BANKS on read: S1 value = 0 (black).
- Fade FSM states: IDLE, FADE_OUT, FADE_IN.
  - IDLE: fade_req=1 -> FADE_OUT if fade_dir=0, else FADE_IN. fade_busy = 1 from the next cycle.
  - FADE_OUT: each frame_start, level = max(0, level-FADE_STEP). When the result is 0 -> IDLE.
  - FADE_IN: each frame_start, level = min(2**CH_W, level+FADE_STEP). When the result is 2**CH_W -> IDLE.
  - fade_req while busy is ignored; no queueing.
  - Request toward a level already reached: enters the fade state, clamps on the next frame_start, then IDLE. fade_busy is high for that span.
  - fade_req and frame_start in the same IDLE cycle: request accepted, no step that cycle.
- Palette writes and fades are independent. Writes during a fade are allowed.
- Reset mid-fade or mid-pipeline: immediate return to reset state. In-flight pixels are dropped (out_valid = 0).

Optional Feature:
- Macro: PALETTE_TRANSPARENT_EN
- Defined:
  - Adds output port `transparent` (1 bit), aligned with out_valid.
  - `transparent` = 1 when the pixel's index == 0, regardless of bank or fade.
  - Reset value 0.
  - Used by the sprite compositor as the colour key.
- Undefined:
  - Port absent.
  - Index 0 is an ordinary colour.

Test Plan:
- Reset, then pix_valid=1, index=9, bank_sel=0 at cycle 0 -> cycle 2: out_valid=1, RGB={9,9,9}; fade_level=16.
- Write bank1 entry 3 = 12'hF80, then read bank1 index 3 -> RGB={F,8,0}. Same-cycle write+read of bank0 entry 5 = 12'h123 -> old {5,5,5} returned; a subsequent read returns {1,2,3}.
- fade_req, fade_dir=0, FADE_STEP=4, then 4 frame_start pulses:
  - fade_level 16 -> 12 -> 8 -> 4 -> 0; fade_busy drops after the 4th pulse.
  - Entry {F,8,0} at level 8 reads {7,4,0}.
  - At level 0 all reads = 0.
- During FADE_OUT, fade_req with fade_dir=1 is ignored. After IDLE, a fade_in request at FADE_STEP=1 takes 16 frames to restore level 16.
- bank_sel=2 with BANKS=2 -> RGB=0; wr_bank=3 write -> no bank changes. Reset asserted mid-fade at level 8 -> fade_level=16, fade_busy=0, out_valid=0 immediately.
- PALETTE_TRANSPARENT_EN defined: index 0 -> transparent=1 two cycles later; index 1 -> 0. Macro undefined: build without the port passes.
